seg_time_decoder: RTL and testbench

- Reads a scanned seven-segment display stream (one digit per sample strobe) and turns it back into binary hour/minute/second.
- It is the decode-side counterpart of the clock's segment output path: segment patterns in, time values out.
- Used as an on-chip readback/monitor of the clock display and as a checker in system benches.
- Filters frames for stability and range before declaring the time valid.

---
 rtl/seg_time_decoder_pkg.sv | 34 +++
 rtl/seg_time_decoder_seg_to_bcd.sv | 29 ++
 rtl/seg_time_decoder.sv | 194 +++++++++++++++++++
 tb/tb_seg_time_decoder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_time_decoder_pkg.sv
// Shared constants for the seven-segment time decoder: segment codes, digit slots, limits.
package seg_time_decoder_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam int unsigned HT = 5;
  localparam int unsigned HO = 4;
  localparam int unsigned MT = 3;
  localparam int unsigned MO = 2;
  localparam int unsigned ST = 1;
  localparam int unsigned SO = 0;

  localparam logic [6:0] MAX_HOUR   = 7'd23;
  localparam logic [6:0] MAX_MINSEC = 7'd59;

  typedef enum logic {
    COLLECT = 1'b0,
    EVAL    = 1'b1
  } state_e;

  function automatic logic is_onehot6(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/seg_time_decoder_seg_to_bcd.sv
// Combinational decoder from an active-high seven-segment pattern to a BCD digit plus legality flag.
module seg_to_bcd
  import seg_time_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       legal
);

  // Pattern lookup; anything outside the ten digit shapes is illegal
  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_time_decoder.sv
// Scanned seven-segment display readback: digits in, stable hour/minute/second out.
// Optional watchdog enabled by defining SEG_TIME_DECODER_TIMEOUT_EN.
module seg_time_decoder
  import seg_time_decoder_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned STABLE_FRAMES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic [5:0] dig_sel,
  input  logic [6:0] seg_in,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       time_valid,
  output logic       frame_done,
  output logic       err_seg,
  output logic       err_sel,
  output logic       err_range
);

  localparam logic [3:0] STABLE_K = 4'(STABLE_FRAMES);

  logic [6:0] seg_hi_s;
  logic [3:0] bcd_s;
  logic       legal_s;
  logic       sel_ok_s;
  logic       seg_bad_s;
  logic       frame_ready_s;
  logic       timeout_s;
  logic       in_range_s;
  logic       same_s;
  logic [5:0] mask_r;
  logic [5:0] mask_next_s;
  logic [3:0] digit_r [6];
  logic [6:0] h_s, m_s, s_s;
  logic [6:0] hf_r, mf_r, sf_r;
  logic [6:0] ph_r, pm_r, ps_r;
  logic [3:0] cnt_r;
  logic [3:0] cnt_next_s;
  state_e     state_r;

  assign seg_hi_s      = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
  assign sel_ok_s      = is_onehot6(dig_sel);
  assign seg_bad_s     = sample_en && sel_ok_s && !legal_s;
  assign frame_ready_s = (state_r == COLLECT) && (mask_r == 6'h3F);

  seg_to_bcd u_seg_to_bcd (
    .seg   (seg_hi_s),
    .digit (bcd_s),
    .legal (legal_s)
  );

  assign h_s = {3'b000, digit_r[HT]} * 7'd10 + {3'b000, digit_r[HO]};
  assign m_s = {3'b000, digit_r[MT]} * 7'd10 + {3'b000, digit_r[MO]};
  assign s_s = {3'b000, digit_r[ST]} * 7'd10 + {3'b000, digit_r[SO]};

  assign in_range_s = (hf_r <= MAX_HOUR) && (mf_r <= MAX_MINSEC) && (sf_r <= MAX_MINSEC);
  assign same_s     = ({hf_r, mf_r, sf_r} == {ph_r, pm_r, ps_r});

  // Stability counter successor for a legal frame, saturating at 15
  always_comb begin
    if (!same_s) begin
      cnt_next_s = 4'd1;
    end else if (cnt_r == 4'd15) begin
      cnt_next_s = 4'd15;
    end else begin
      cnt_next_s = cnt_r + 4'd1;
    end
  end

  // A completed mask is handed to EVAL and emptied on the same edge, so a strobe there starts the next frame
  always_comb begin
    mask_next_s = frame_ready_s ? 6'd0 : mask_r;
    if (sample_en && sel_ok_s) begin
      if (legal_s) begin
        mask_next_s = mask_next_s | dig_sel;
      end else begin
        mask_next_s = 6'd0;
      end
    end else begin
      mask_next_s = mask_next_s;
    end
    if (timeout_s) begin
      mask_next_s = 6'd0;
    end else begin
      mask_next_s = mask_next_s;
    end
  end

  // Per-slot digit storage; a repeated slot simply overwrites
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) digit_r[i] <= 4'd0;
    end else if (sample_en && sel_ok_s && legal_s) begin
      for (int i = 0; i < 6; i++) begin
        if (dig_sel[i]) digit_r[i] <= bcd_s;
      end
    end
  end

  // Frame FSM, stability tracking and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= COLLECT;
      mask_r       <= 6'd0;
      hf_r         <= 7'd0;
      mf_r         <= 7'd0;
      sf_r         <= 7'd0;
      ph_r         <= 7'd0;
      pm_r         <= 7'd0;
      ps_r         <= 7'd0;
      cnt_r        <= 4'd0;
      hour         <= 5'd0;
      minute       <= 6'd0;
      second       <= 6'd0;
      time_valid   <= 1'b0;
      frame_done   <= 1'b0;
      err_seg      <= 1'b0;
      err_sel      <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      mask_r     <= mask_next_s;
      err_sel    <= sample_en && !sel_ok_s;
      err_seg    <= seg_bad_s;
      frame_done <= 1'b0;
      err_range  <= 1'b0;
      case (state_r)
        COLLECT: begin
          if (frame_ready_s) begin
            state_r <= EVAL;
            hf_r    <= h_s;
            mf_r    <= m_s;
            sf_r    <= s_s;
          end else begin
            state_r <= COLLECT;
          end
        end
        EVAL: begin
          state_r <= COLLECT;
          if (in_range_s) begin
            frame_done <= 1'b1;
            cnt_r      <= cnt_next_s;
            ph_r       <= hf_r;
            pm_r       <= mf_r;
            ps_r       <= sf_r;
            if (cnt_next_s >= STABLE_K) begin
              hour       <= hf_r[4:0];
              minute     <= mf_r[5:0];
              second     <= sf_r[5:0];
              time_valid <= 1'b1;
            end else begin
              time_valid <= 1'b0;
            end
          end else begin
            err_range  <= 1'b1;
            cnt_r      <= 4'd0;
            time_valid <= 1'b0;
          end
        end
        default: state_r <= COLLECT;
      endcase
      // Corrupt digits or a stalled display invalidate everything gathered so far
      if (seg_bad_s || timeout_s) begin
        cnt_r      <= 4'd0;
        time_valid <= 1'b0;
      end
    end
  end

`ifdef SEG_TIME_DECODER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_r;

  assign timeout_s = (wd_r == WD_W'(TIMEOUT_CYCLES - 1));

  // Cycles since the last accepted frame, saturating once the watchdog has fired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_r <= '0;
    end else if (frame_done) begin
      wd_r <= '0;
    end else if (wd_r != WD_W'(TIMEOUT_CYCLES)) begin
      wd_r <= wd_r + 1'b1;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

endmodule

// File: tb/tb_seg_time_decoder.sv
// Randomized self-checking bench for seg_time_decoder against a frame-level reference model.
module tb_seg_time_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_en;
  logic [5:0] dig_sel;
  logic [6:0] seg_in;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic       time_valid, frame_done, err_seg, err_sel, err_range;

  int checks   = 0;
  int failures = 0;

  // reference model state (whole-frame view)
  int mp_h, mp_m, mp_s, m_cnt;
  int m_h, m_m, m_s;
  bit m_valid;

  logic [6:0] seg_tab [10];
  logic [6:0] bad_tab [5];

  always #5 clk = ~clk;

  seg_time_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .dig_sel    (dig_sel),
    .seg_in     (seg_in),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .time_valid (time_valid),
    .frame_done (frame_done),
    .err_seg    (err_seg),
    .err_sel    (err_sel),
    .err_range  (err_range)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mp_h = 0; mp_m = 0; mp_s = 0; m_cnt = 0;
    m_h = 0; m_m = 0; m_s = 0; m_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_hour"}, 32'(hour), 32'd0);
    check_eq({tag, "_minute"}, 32'(minute), 32'd0);
    check_eq({tag, "_second"}, 32'(second), 32'd0);
    check_eq({tag, "_valid"}, 32'(time_valid), 32'd0);
    check_eq({tag, "_flags"}, 32'({frame_done, err_seg, err_sel, err_range}), 32'd0);
  endtask

  // one strobe (active-high pattern given, driven active-low); returns at the next falling edge
  task automatic strobe(input logic [5:0] sel, input logic [6:0] pat_hi);
    @(negedge clk);
    sample_en = 1'b1;
    dig_sel   = sel;
    seg_in    = ~pat_hi;
    @(negedge clk);
    sample_en = 1'b0;
    dig_sel   = 6'd0;
    seg_in    = 7'h7F;
  endtask

  task automatic partial_frame(input int n);
    for (int i = 0; i < n; i++) strobe(6'b000001 << i, seg_tab[$urandom_range(0, 9)]);
  endtask

  task automatic illegal_strobe(input logic [6:0] pat_hi);
    strobe(6'b000001 << $urandom_range(0, 5), pat_hi);
    m_cnt = 0;
    m_valid = 1'b0;
    check_eq("err_seg", 32'(err_seg), 32'd1);
    check_eq("err_seg_sel", 32'(err_sel), 32'd0);
    check_eq("err_seg_valid", 32'(time_valid), 32'd0);
  endtask

  // inject=1 slips a two-hot select into the middle of the frame
  task automatic send_frame(input int h, input int m, input int s, input int inject);
    int d[6];
    int ord[6];
    logic [5:0] sel;
    d[5] = h / 10; d[4] = h % 10;
    d[3] = m / 10; d[2] = m % 10;
    d[1] = s / 10; d[0] = s % 10;
    for (int i = 0; i < 6; i++) ord[i] = i;
    for (int i = 5; i > 0; i--) begin
      int j = int'($urandom_range(0, i));
      int t = ord[i];
      ord[i] = ord[j];
      ord[j] = t;
    end
    if ($urandom_range(0, 3) == 0) strobe(6'b000001 << ord[0], seg_tab[$urandom_range(0, 9)]);
    for (int i = 0; i < 6; i++) begin
      sel = 6'b000001 << ord[i];
      strobe(sel, seg_tab[d[ord[i]]]);
      if (inject == 1 && i == 2) begin
        strobe(6'b000011, seg_tab[1]);
        check_eq("err_sel", 32'(err_sel), 32'd1);
        check_eq("err_sel_valid_hold", 32'(time_valid), 32'(m_valid));
      end
      if (i < 5) repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    if (h > 23 || m > 59 || s > 59) begin
      m_cnt = 0;
      m_valid = 1'b0;
      check_eq("range_frame_done", 32'(frame_done), 32'd0);
      check_eq("range_err", 32'(err_range), 32'd1);
    end else begin
      if (h == mp_h && m == mp_m && s == mp_s) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else m_cnt = 1;
      mp_h = h; mp_m = m; mp_s = s;
      if (m_cnt >= 2) begin
        m_valid = 1'b1;
        m_h = h; m_m = m; m_s = s;
      end else begin
        m_valid = 1'b0;
      end
      check_eq("frame_done", 32'(frame_done), 32'd1);
      check_eq("no_err_range", 32'(err_range), 32'd0);
    end
    check_eq("time_valid", 32'(time_valid), 32'(m_valid));
    check_eq("hour", 32'(hour), 32'(m_h));
    check_eq("minute", 32'(minute), 32'(m_m));
    check_eq("second", 32'(second), 32'(m_s));
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int h, m, s, mode;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    bad_tab = '{7'h00, 7'h7E, 7'h01, 7'h40, 7'h3E};
    rst_n = 1'b0; sample_en = 1'b0; dig_sel = 6'd0; seg_in = 7'h7F;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("post_reset");

    send_frame(12, 34, 56, 0);
    send_frame(12, 34, 56, 0);
    partial_frame(3);
    illegal_strobe(7'h00);
    send_frame(12, 34, 56, 0);
    send_frame(12, 34, 56, 0);
    send_frame(12, 34, 56, 1);
    send_frame(25, 10, 0, 0);
    send_frame(12, 60, 0, 0);
    send_frame(23, 59, 59, 0);
    send_frame(23, 59, 59, 0);
    send_frame(0, 0, 0, 0);
    send_frame(0, 0, 0, 0);

    repeat (200) @(negedge clk);
    check_eq("idle_valid", 32'(time_valid), 32'(m_valid));
    check_eq("idle_hour", 32'(hour), 32'(m_h));

    partial_frame(3);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    rst_n = 1'b1;
    model_reset();
    send_frame(7, 8, 9, 0);
    send_frame(7, 8, 9, 0);

    h = 7; m = 8; s = 9;
    for (int it = 0; it < 60; it++) begin
      mode = int'($urandom_range(0, 19));
      if (mode < 9) begin
        // repeat previous frame
      end else if (mode < 14) begin
        h = int'($urandom_range(0, 23));
        m = int'($urandom_range(0, 59));
        s = int'($urandom_range(0, 59));
      end else if (mode < 17) begin
        h = int'($urandom_range(0, 99));
        m = int'($urandom_range(0, 99));
        s = int'($urandom_range(0, 99));
      end else begin
        partial_frame(int'($urandom_range(0, 5)));
        illegal_strobe(bad_tab[$urandom_range(0, 4)]);
      end
      send_frame(h, m, s, ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
